// File: rtl/freelist_ctrl_pkg.sv
// Shared core constants and types for the rename free list.
package freelist_ctrl_pkg;

  localparam int CORE_NUM_PREGS = 32;
  localparam int CORE_NUM_ARCH  = 16;
  localparam int CORE_TAG_W     = 5;

  typedef struct packed {
    logic [1:0] en;
    logic       stall;
  } fl_grant_t;

  function automatic logic [1:0] popcnt2(input logic [1:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]};
  endfunction

endpackage

// File: rtl/freelist_ctrl.sv
// Two-wide physical-register free list with speculative/commit heads and
// mispredict recovery; grants are combinational from registered state.
module freelist_ctrl
  import freelist_ctrl_pkg::*;
#(
  parameter  int NUM_PREGS = CORE_NUM_PREGS,
  parameter  int NUM_ARCH  = CORE_NUM_ARCH,
  parameter  int TAG_W     = CORE_TAG_W,
  localparam int DEPTH     = NUM_PREGS - NUM_ARCH,
  localparam int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  recovery_en,
  input  logic [1:0]            alloc_req,
  input  logic [1:0]            retire_en,
  input  logic [1:0][TAG_W-1:0] retire_old_tag,
  output logic [1:0]            freelist_en,
  output logic [1:0][TAG_W-1:0] next_free,
  output logic                  alloc_stall,
  output logic [CNT_W-1:0]      free_count,
  output logic                  err
);

  localparam int               PTR_W   = $clog2(DEPTH);
  localparam logic [PTR_W:0]   DEPTH_P = (PTR_W+1)'(DEPTH);
  localparam logic [CNT_W:0]   DEPTH_C = (CNT_W+1)'(DEPTH);

  logic [TAG_W-1:0] tags [DEPTH];
  logic [PTR_W-1:0] spec_head;
  logic [PTR_W-1:0] commit_head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic             err_flag;

  fl_grant_t        grant;
  logic [1:0]       alloc_k;
  logic [1:0]       granted_k;
  logic [1:0]       ret_k;
  logic [1:0]       eff_ret_en;
  logic [1:0]       eff_ret_k;
  logic [PTR_W-1:0] head_plus1;
  logic [PTR_W-1:0] tail_slot1;
  logic [PTR_W-1:0] commit_nxt;
  logic [CNT_W:0]   count_sum;
  logic [CNT_W:0]   count_nxt;
  logic             ovf;
  logic             under;

  // Pointer advance by 0..2 with wrap at DEPTH (DEPTH need not be a power of two).
  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] ptr,
                                                 input logic [1:0]       inc);
    logic [PTR_W:0] sum;
    sum = {1'b0, ptr} + (PTR_W+1)'(inc);
    if (sum >= DEPTH_P) sum = sum - DEPTH_P;
    return sum[PTR_W-1:0];
  endfunction

  always_comb begin
    alloc_k = popcnt2(alloc_req);
    grant   = '0;
    if (!rst && !recovery_en && alloc_k != 2'd0) begin
      if (CNT_W'(alloc_k) <= count) grant.en    = alloc_req;
      else                          grant.stall = 1'b1;
    end
    granted_k = (grant.en != 2'b00) ? alloc_k : 2'd0;
  end

  // Lowest requesting slot takes the head; slot1 takes head+1 only if slot0 also asked.
  always_comb begin
    head_plus1   = wrap_add(spec_head, 2'd1);
    next_free[0] = tags[spec_head];
    next_free[1] = alloc_req[0] ? tags[head_plus1] : tags[spec_head];
  end

  // Retires that would overfill the list are dropped and flagged.
  always_comb begin
    ret_k      = popcnt2(retire_en);
    count_sum  = {1'b0, count} + (CNT_W+1)'(ret_k) - (CNT_W+1)'(granted_k);
    ovf        = count_sum > DEPTH_C;
    under      = (CNT_W+1)'(granted_k) > {1'b0, count};
    eff_ret_en = ovf ? 2'b00 : retire_en;
    eff_ret_k  = ovf ? 2'd0  : ret_k;
    count_nxt  = ovf ? ({1'b0, count} - (CNT_W+1)'(granted_k)) : count_sum;
    tail_slot1 = eff_ret_en[0] ? wrap_add(tail, 2'd1) : tail;
    commit_nxt = wrap_add(commit_head, eff_ret_k);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) tags[i] <= TAG_W'(NUM_ARCH + i);
      spec_head   <= '0;
      commit_head <= '0;
      tail        <= '0;
      count       <= CNT_W'(DEPTH);
      err_flag    <= 1'b0;
    end else begin
      if (eff_ret_en[0]) tags[tail]       <= retire_old_tag[0];
      if (eff_ret_en[1]) tags[tail_slot1] <= retire_old_tag[1];
      tail        <= wrap_add(tail, eff_ret_k);
      commit_head <= commit_nxt;
      if (recovery_en) begin
        spec_head <= commit_nxt;
        count     <= CNT_W'(DEPTH);
      end else begin
        spec_head <= wrap_add(spec_head, granted_k);
        count     <= count_nxt[CNT_W-1:0];
      end
      if (ovf || under) err_flag <= 1'b1;
    end
  end

  assign freelist_en = grant.en;
  assign alloc_stall = grant.stall;
  assign free_count  = count;
  assign err         = err_flag;

endmodule

// File: tb/tb_freelist_ctrl.sv
// Directed bench for freelist_ctrl with a reference queue for the wrap run.
module tb_freelist_ctrl;

  logic            clk = 1'b0;
  logic            rst;
  logic            recovery_en;
  logic [1:0]      alloc_req;
  logic [1:0]      retire_en;
  logic [1:0][4:0] retire_old_tag;
  logic [1:0]      freelist_en;
  logic [1:0][4:0] next_free;
  logic            alloc_stall;
  logic [4:0]      free_count;
  logic            err;

  int tests = 0;
  int fails = 0;
  int q[$];

  always #5 clk = ~clk;

  freelist_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .recovery_en   (recovery_en),
    .alloc_req     (alloc_req),
    .retire_en     (retire_en),
    .retire_old_tag(retire_old_tag),
    .freelist_en   (freelist_en),
    .next_free     (next_free),
    .alloc_stall   (alloc_stall),
    .free_count    (free_count),
    .err           (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] a, input logic [1:0] r,
                       input int t0, input int t1, input logic rec);
    alloc_req         = a;
    retire_en         = r;
    retire_old_tag[0] = 5'(t0);
    retire_old_tag[1] = 5'(t1);
    recovery_en       = rec;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    drive(2'b00, 2'b00, 0, 0, 1'b0);
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    // Reset held with every other input active: reset must win.
    rst = 1'b1;
    drive(2'b11, 2'b11, 1, 2, 1'b1);
    step();
    #2;
    chk("rst_en", 32'(freelist_en), 0);
    chk("rst_stall", 32'(alloc_stall), 0);
    step();
    rst = 1'b0;
    drive(2'b00, 2'b00, 0, 0, 1'b0);
    #2;
    chk("rst_count", 32'(free_count), 16);
    chk("rst_err", 32'(err), 0);

    // First dual grant, then slot1-only ordering.
    drive(2'b11, 2'b00, 0, 0, 1'b0);
    #2;
    chk("first_nf0", 32'(next_free[0]), 16);
    chk("first_nf1", 32'(next_free[1]), 17);
    chk("first_en", 32'(freelist_en), 3);
    chk("first_stall", 32'(alloc_stall), 0);
    step();
    chk("first_count", 32'(free_count), 14);
    drive(2'b10, 2'b00, 0, 0, 1'b0);
    #2;
    chk("slot1_nf1", 32'(next_free[1]), 18);
    chk("slot1_en", 32'(freelist_en), 2);
    step();
    chk("slot1_count", 32'(free_count), 13);

    // Drain with single allocations, then stall on empty.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive(2'b01, 2'b00, 0, 0, 1'b0);
      #2;
      chk("drain_tag", 32'(next_free[0]), 32'(16 + i));
      step();
    end
    drive(2'b00, 2'b00, 0, 0, 1'b0);
    chk("empty_count", 32'(free_count), 0);
    drive(2'b01, 2'b00, 0, 0, 1'b0);
    #2;
    chk("empty_stall", 32'(alloc_stall), 1);
    chk("empty_en", 32'(freelist_en), 0);
    step();
    chk("empty_count_hold", 32'(free_count), 0);
    chk("empty_err", 32'(err), 0);

    // One free, dual request stalls while a retire lands; next cycle both granted.
    drive(2'b00, 2'b01, 7, 0, 1'b0);
    step();
    chk("one_count", 32'(free_count), 1);
    drive(2'b11, 2'b01, 3, 0, 1'b0);
    #2;
    chk("one_stall", 32'(alloc_stall), 1);
    chk("one_en", 32'(freelist_en), 0);
    step();
    chk("one_retire_count", 32'(free_count), 2);
    drive(2'b11, 2'b00, 0, 0, 1'b0);
    #2;
    chk("one_nf0", 32'(next_free[0]), 7);
    chk("one_nf1", 32'(next_free[1]), 3);
    chk("one_en2", 32'(freelist_en), 3);
    step();
    chk("one_count_after", 32'(free_count), 0);

    // Recovery rewinds the spec head to the commit head.
    do_reset();
    drive(2'b11, 2'b00, 0, 0, 1'b0);
    step();
    step();
    drive(2'b00, 2'b00, 0, 0, 1'b0);
    chk("rec_alloc_count", 32'(free_count), 12);
    drive(2'b00, 2'b11, 5, 6, 1'b0);
    step();
    chk("rec_retire_count", 32'(free_count), 14);
    drive(2'b11, 2'b00, 0, 0, 1'b1);
    #2;
    chk("rec_en", 32'(freelist_en), 0);
    chk("rec_stall", 32'(alloc_stall), 0);
    step();
    chk("rec_count", 32'(free_count), 16);
    step();
    chk("rec_count_hold", 32'(free_count), 16);
    drive(2'b11, 2'b00, 0, 0, 1'b0);
    #2;
    chk("rec_nf0", 32'(next_free[0]), 18);
    chk("rec_nf1", 32'(next_free[1]), 19);
    step();
    chk("rec_after_count", 32'(free_count), 14);

    // Steady dual alloc + dual retire against a reference queue.
    do_reset();
    q.delete();
    for (int i = 0; i < 16; i++) q.push_back(16 + i);
    for (int c = 0; c < 40; c++) begin
      int e0;
      int e1;
      int r0;
      int r1;
      r0 = (2 * c) % 16;
      r1 = (2 * c + 1) % 16;
      drive(2'b11, 2'b11, r0, r1, 1'b0);
      e0 = q.pop_front();
      e1 = q.pop_front();
      #2;
      chk("wrap_nf0", 32'(next_free[0]), 32'(e0));
      chk("wrap_nf1", 32'(next_free[1]), 32'(e1));
      chk("wrap_en", 32'(freelist_en), 3);
      q.push_back(r0);
      q.push_back(r1);
      step();
    end
    drive(2'b00, 2'b00, 0, 0, 1'b0);
    chk("wrap_count", 32'(free_count), 16);
    chk("wrap_err", 32'(err), 0);

    // Overfill sets a sticky error cleared only by reset.
    do_reset();
    drive(2'b00, 2'b01, 1, 0, 1'b0);
    step();
    drive(2'b00, 2'b00, 0, 0, 1'b0);
    chk("ovf_err", 32'(err), 1);
    chk("ovf_count", 32'(free_count), 16);
    step();
    step();
    chk("ovf_err_sticky", 32'(err), 1);
    do_reset();
    chk("ovf_err_cleared", 32'(err), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
